// File: rtl/hdc_classify_ctrl.sv
// Sequencer for the HDC spam/ham classifier: tokenizes a byte stream, then sweeps the
// datapath through clear/accumulate/threshold/score passes. Optional define: HDC_SKIP_OTHER_EN.
module hdc_classify_ctrl #(
    parameter int DIM        = 10000,
    parameter int LANES      = 16,
    parameter int NUM_CHAR   = 37,
    parameter int MAX_LENGTH = 200,
    parameter int PIPE_LAT   = 3,
    parameter int SCORE_W    = 32,
    localparam int WORDS     = DIM / LANES,
    localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int TW        = $clog2(NUM_CHAR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               char_valid,
    input  logic [7:0]         char_data,
    input  logic               char_last,
    output logic               char_ready,
    output logic [AW-1:0]      word_addr,
    output logic [TW-1:0]      im_token,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               thr_en,
    output logic               dot_en,
    output logic [7:0]         msg_len,
    input  logic [SCORE_W-1:0] ham_score,
    input  logic [SCORE_W-1:0] spam_score,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic               busy,
    output logic               trunc
);

    localparam int BW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [AW-1:0] LAST_WORD  = AW'(WORDS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);
    localparam logic [7:0]    MAX_LEN    = 8'(MAX_LENGTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_ACCUM, S_DRAIN_A,
        S_THRESH, S_DRAIN_T, S_SCORE, S_DRAIN_S, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [7:0]    tok_q, tok_d;
    logic [DW-1:0] drn_q, drn_d;
    logic [7:0]    msg_len_q, msg_len_d;
    logic          trunc_q, trunc_d;
    logic [1:0]    result_q, result_d;
    logic          rv_q, rv_d;
    logic [TW-1:0] buf_q [MAX_LENGTH];

    logic [TW-1:0] cur_tok;
    logic [7:0]    base_len, new_len;
    logic          accept, room, store, wr_en, sweep_end, drain_end;

    function automatic logic [TW-1:0] tokenize(input logic [7:0] ch);
        logic [7:0] c;
        c = (ch >= 8'h41 && ch <= 8'h5A) ? (ch | 8'h20) : ch;
        if (c >= 8'h61 && c <= 8'h7A)      tokenize = TW'(c - 8'h56);
        else if (c >= 8'h30 && c <= 8'h39) tokenize = TW'(c - 8'h2F);
        else                               tokenize = '0;
    endfunction

    assign cur_tok  = tokenize(char_data);
    // A new message restarts the count from zero on its first byte.
    assign base_len = (state_q == S_IDLE) ? 8'd0 : msg_len_q;
    assign room     = base_len < MAX_LEN;
`ifdef HDC_SKIP_OTHER_EN
    assign store    = (cur_tok != '0);
`else
    assign store    = 1'b1;
`endif
    assign new_len  = base_len + {7'd0, store & room};
    assign accept   = char_valid & char_ready;
    assign wr_en    = accept & store & room;
    assign sweep_end = (word_q == LAST_WORD);
    assign drain_end = (drn_q == LAST_DRAIN);

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        tok_d     = tok_q;
        drn_d     = drn_q;
        msg_len_d = msg_len_q;
        trunc_d   = trunc_q;
        result_d  = result_q;
        rv_d      = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    msg_len_d = new_len;
                    trunc_d   = ((state_q == S_IDLE) ? 1'b0 : trunc_q) | (store & ~room);
                    state_d   = S_LOAD;
                    if (char_last) begin
                        if (new_len == 8'd0) begin
                            state_d  = S_DONE;
                            result_d = 2'b11;
                            rv_d     = 1'b1;
                        end else begin
                            state_d  = S_CLEAR;
                        end
                    end
                end
            end
            S_CLEAR, S_THRESH, S_SCORE: begin
                word_d = sweep_end ? '0 : word_q + AW'(1);
                tok_d  = 8'd0;
                if (sweep_end) begin
                    case (state_q)
                        S_CLEAR:  state_d = S_ACCUM;
                        S_THRESH: state_d = S_DRAIN_T;
                        default:  state_d = S_DRAIN_S;
                    endcase
                end
            end
            S_ACCUM: begin
                word_d = sweep_end ? '0 : word_q + AW'(1);
                if (sweep_end) begin
                    if (tok_q == msg_len_q - 8'd1) begin
                        tok_d   = 8'd0;
                        state_d = S_DRAIN_A;
                    end else begin
                        tok_d   = tok_q + 8'd1;
                    end
                end
            end
            S_DRAIN_A, S_DRAIN_T, S_DRAIN_S: begin
                drn_d = drain_end ? '0 : drn_q + DW'(1);
                if (drain_end) begin
                    case (state_q)
                        S_DRAIN_A: state_d = S_THRESH;
                        S_DRAIN_T: state_d = S_SCORE;
                        default: begin
                            // Scores are settled on the edge that closes the final drain.
                            state_d = S_DONE;
                            rv_d    = 1'b1;
                            if ($signed(ham_score) > $signed(spam_score))      result_d = 2'b00;
                            else if ($signed(ham_score) < $signed(spam_score)) result_d = 2'b01;
                            else                                               result_d = 2'b11;
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            tok_q     <= 8'd0;
            drn_q     <= '0;
            msg_len_q <= 8'd0;
            trunc_q   <= 1'b0;
            result_q  <= 2'b00;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            tok_q     <= tok_d;
            drn_q     <= drn_d;
            msg_len_q <= msg_len_d;
            trunc_q   <= trunc_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[base_len[BW-1:0]] <= cur_tok;
    end

    assign char_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy         = ~char_ready;
    assign acc_clr      = (state_q == S_CLEAR);
    assign acc_en       = (state_q == S_ACCUM);
    assign thr_en       = (state_q == S_THRESH);
    assign dot_en       = (state_q == S_SCORE);
    assign word_addr    = word_q;
    assign im_token     = acc_en ? buf_q[tok_q[BW-1:0]] : '0;
    assign msg_len      = msg_len_q;
    assign trunc        = trunc_q;
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Directed bench for hdc_classify_ctrl with DIM=64, LANES=16 (WORDS=4), PIPE_LAT=2, MAX_LENGTH=4.
module tb_hdc_classify_ctrl;

    localparam int W = 4;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid, char_last;
    logic [7:0]  char_data;
    logic        char_ready, acc_clr, acc_en, thr_en, dot_en;
    logic [1:0]  word_addr;
    logic [5:0]  im_token;
    logic [7:0]  msg_len;
    logic [31:0] ham_score, spam_score;
    logic [1:0]  result;
    logic        result_valid, busy, trunc;

    hdc_classify_ctrl #(.DIM(64), .LANES(16), .NUM_CHAR(37), .MAX_LENGTH(4),
                        .PIPE_LAT(2), .SCORE_W(32)) dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_last(char_last), .char_ready(char_ready), .word_addr(word_addr),
        .im_token(im_token), .acc_clr(acc_clr), .acc_en(acc_en), .thr_en(thr_en),
        .dot_en(dot_en), .msg_len(msg_len), .ham_score(ham_score), .spam_score(spam_score),
        .result(result), .result_valid(result_valid), .busy(busy), .trunc(trunc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int code_a [256];
    int addr_a [256];
    int tok_a  [256];
    int len_a  [256];
    int exp_tok [8];
    int rv_cyc, busy_err, ready_err;
    logic [1:0] res_s;
    logic post_ready, post_busy, post_rv;
    logic [1:0] post_result;

    task automatic send(input string s, input bit hold);
        for (int i = 0; i < s.len(); i++) begin
            char_valid = 1'b1;
            char_data  = s[i];
            char_last  = (i == s.len() - 1);
            @(posedge clk); #1;
        end
        if (hold) begin
            char_data = 8'h7A;
            char_last = 1'b1;
        end else begin
            char_valid = 1'b0;
            char_last  = 1'b0;
        end
    endtask

    // Records strobe code (0 none, 1 clr, 2 acc, 3 thr, 4 dot, 7 overlap) per cycle until result_valid.
    task automatic capture(input int maxc);
        rv_cyc = -1; busy_err = 0; ready_err = 0;
        for (int c = 1; c <= maxc; c++) begin
            int k;
            k = 0;
            if (acc_clr) k++;
            if (acc_en)  k++;
            if (thr_en)  k++;
            if (dot_en)  k++;
            code_a[c] = (k > 1) ? 7 : acc_clr ? 1 : acc_en ? 2 : thr_en ? 3 : dot_en ? 4 : 0;
            addr_a[c] = int'(word_addr);
            tok_a[c]  = int'(im_token);
            len_a[c]  = int'(msg_len);
            if (busy !== 1'b1) busy_err++;
            if (char_ready !== 1'b0) ready_err++;
            if (result_valid === 1'b1) begin
                rv_cyc = c;
                res_s  = result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        post_ready = char_ready; post_busy = busy; post_rv = result_valid; post_result = result;
    endtask

    function automatic int sched_errs(input int n);
        int e, ae, rv, ec, ea, et;
        e  = 0;
        ae = (n + 1) * W;
        rv = (n + 3) * W + 3 * P + 1;
        for (int c = 1; c < rv; c++) begin
            ec = 0; ea = 0; et = 0;
            if (c <= W) begin
                ec = 1; ea = c - 1;
            end else if (c <= ae) begin
                ec = 2; ea = (c - W - 1) % W; et = exp_tok[(c - W - 1) / W];
            end else if (c > ae + P && c <= ae + P + W) begin
                ec = 3; ea = c - ae - P - 1;
            end else if (c > ae + 2*P + W && c <= ae + 2*P + 2*W) begin
                ec = 4; ea = c - ae - 2*P - W - 1;
            end
            if (code_a[c] != ec || addr_a[c] != ea || tok_a[c] != et) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0; char_valid = 1'b0; char_last = 1'b0; char_data = 8'h00;
        ham_score = 32'sd0; spam_score = 32'sd0;
        @(posedge clk); @(posedge clk); #1;
        n_vec++;
        if ({char_ready, busy, acc_clr, acc_en, thr_en, dot_en, word_addr, im_token, msg_len, result, result_valid, trunc}
            !== {1'b1, 1'b0, 4'b0000, 2'd0, 6'd0, 8'd0, 2'b00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values got rdy=%b busy=%b strb=%b%b%b%b addr=%0d tok=%0d len=%0d res=%b rv=%b trunc=%b",
                     char_ready, busy, acc_clr, acc_en, thr_en, dot_en, word_addr, im_token, msg_len, result, result_valid, trunc);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ab1();
        ham_score = 32'sd100; spam_score = -32'sd5;
        exp_tok[0] = 11; exp_tok[1] = 12; exp_tok[2] = 2;
        send("Ab1", 1'b0);
        capture(60);
        n_vec++;
        if (sched_errs(3) !== 0) begin n_bad++; $display("FAIL ab1_schedule bad_cycles=%0d want 0", sched_errs(3)); end
        n_vec++;
        if (rv_cyc !== 31) begin n_bad++; $display("FAIL ab1_rv_cycle got %0d want 31", rv_cyc); end
        n_vec++;
        if (res_s !== 2'b00) begin n_bad++; $display("FAIL ab1_result got %b want 00", res_s); end
        n_vec++;
        if ({msg_len, trunc} !== {8'd3, 1'b0}) begin n_bad++; $display("FAIL ab1_len got len=%0d trunc=%b want 3/0", msg_len, trunc); end
        n_vec++;
        if ({busy_err, ready_err} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL ab1_busy_ready got busy_err=%0d ready_err=%0d want 0/0", busy_err, ready_err); end
        n_vec++;
        if ({post_ready, post_busy, post_rv, post_result} !== {1'b1, 1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL ab1_after_done got rdy=%b busy=%b rv=%b res=%b want 1/0/0/00", post_ready, post_busy, post_rv, post_result);
        end
    endtask

    task automatic test_compare();
        ham_score = 32'sd7; spam_score = 32'sd7;
        send("Ab1", 1'b0);
        capture(60);
        n_vec++;
        if ({rv_cyc, res_s} !== {32'd31, 2'b11}) begin n_bad++; $display("FAIL tie_result got cyc=%0d res=%b want 31/11", rv_cyc, res_s); end
        ham_score = -32'sd3; spam_score = 32'sd4;
        send("Ab1", 1'b0);
        capture(60);
        n_vec++;
        if ({rv_cyc, res_s} !== {32'd31, 2'b01}) begin n_bad++; $display("FAIL spam_result got cyc=%0d res=%b want 31/01", rv_cyc, res_s); end
        n_vec++;
        if (post_result !== 2'b01) begin n_bad++; $display("FAIL result_hold got %b want 01", post_result); end
    endtask

    task automatic test_trunc();
        exp_tok[0] = 11; exp_tok[1] = 12; exp_tok[2] = 13; exp_tok[3] = 14;
        send("abcdef", 1'b0);
        capture(80);
        n_vec++;
        if (sched_errs(4) !== 0) begin n_bad++; $display("FAIL trunc_schedule bad_cycles=%0d want 0", sched_errs(4)); end
        n_vec++;
        if ({rv_cyc, msg_len, trunc} !== {32'd35, 8'd4, 1'b1}) begin
            n_bad++; $display("FAIL trunc_len got cyc=%0d len=%0d trunc=%b want 35/4/1", rv_cyc, msg_len, trunc);
        end
        send("9", 1'b0);
        n_vec++;
        if ({msg_len, trunc} !== {8'd1, 1'b0}) begin n_bad++; $display("FAIL trunc_clear got len=%0d trunc=%b want 1/0", msg_len, trunc); end
        exp_tok[0] = 10;
        capture(60);
        n_vec++;
        if ({sched_errs(1), rv_cyc} !== {32'd0, 32'd23}) begin n_bad++; $display("FAIL digit9_run got bad=%0d cyc=%0d want 0/23", sched_errs(1), rv_cyc); end
    endtask

    task automatic test_other();
        send("a-b", 1'b0);
        capture(60);
`ifdef HDC_SKIP_OTHER_EN
        exp_tok[0] = 11; exp_tok[1] = 12;
        n_vec++;
        if ({sched_errs(2), rv_cyc, msg_len} !== {32'd0, 32'd27, 8'd2}) begin
            n_bad++; $display("FAIL other_skip got bad=%0d cyc=%0d len=%0d want 0/27/2", sched_errs(2), rv_cyc, msg_len);
        end
        send("-", 1'b0);
        capture(10);
        n_vec++;
        if ({rv_cyc, res_s, msg_len} !== {32'd1, 2'b11, 8'd0}) begin
            n_bad++; $display("FAIL empty_msg got cyc=%0d res=%b len=%0d want 1/11/0", rv_cyc, res_s, msg_len);
        end
`else
        exp_tok[0] = 11; exp_tok[1] = 0; exp_tok[2] = 12;
        n_vec++;
        if ({sched_errs(3), rv_cyc, msg_len} !== {32'd0, 32'd31, 8'd3}) begin
            n_bad++; $display("FAIL other_keep got bad=%0d cyc=%0d len=%0d want 0/31/3", sched_errs(3), rv_cyc, msg_len);
        end
`endif
    endtask

    task automatic test_reset_mid();
        send("Ab1", 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        n_vec++;
        if ({acc_en, word_addr, im_token} !== {1'b1, 2'd2, 6'd11}) begin
            n_bad++; $display("FAIL mid_accum got acc=%b addr=%0d tok=%0d want 1/2/11", acc_en, word_addr, im_token);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({char_ready, busy, acc_clr, acc_en, thr_en, dot_en, word_addr, im_token, msg_len, result, result_valid, trunc}
            !== {1'b1, 1'b0, 4'b0000, 2'd0, 6'd0, 8'd0, 2'b00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got rdy=%b busy=%b strb=%b%b%b%b addr=%0d tok=%0d len=%0d res=%b",
                     char_ready, busy, acc_clr, acc_en, thr_en, dot_en, word_addr, im_token, msg_len, result);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({char_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL reset_release got rdy=%b busy=%b want 1/0", char_ready, busy); end
        ham_score = 32'sd100; spam_score = -32'sd5;
        exp_tok[0] = 12;
        send("b", 1'b0);
        capture(60);
        n_vec++;
        if ({sched_errs(1), rv_cyc, res_s} !== {32'd0, 32'd23, 2'b00}) begin
            n_bad++; $display("FAIL post_reset_run got bad=%0d cyc=%0d res=%b want 0/23/00", sched_errs(1), rv_cyc, res_s);
        end
    endtask

    task automatic test_back_to_back();
        int le;
        exp_tok[0] = 11; exp_tok[1] = 12;
        send("ab", 1'b1);
        capture(80);
        le = 0;
        for (int c = 1; c <= rv_cyc; c++) if (len_a[c] != 2) le++;
        n_vec++;
        if ({sched_errs(2), rv_cyc} !== {32'd0, 32'd27}) begin n_bad++; $display("FAIL b2b_schedule got bad=%0d cyc=%0d want 0/27", sched_errs(2), rv_cyc); end
        n_vec++;
        if ({le, busy_err, ready_err} !== {32'd0, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL b2b_no_accept got len_err=%0d busy_err=%0d ready_err=%0d want 0/0/0", le, busy_err, ready_err);
        end
        n_vec++;
        if ({post_ready, post_busy} !== 2'b10) begin n_bad++; $display("FAIL b2b_idle got rdy=%b busy=%b want 1/0", post_ready, post_busy); end
        @(posedge clk); #1;
        char_valid = 1'b0; char_last = 1'b0;
        exp_tok[0] = 36;
        n_vec++;
        if ({msg_len, busy, acc_clr} !== {8'd1, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL b2b_next_accept got len=%0d busy=%b clr=%b want 1/1/1", msg_len, busy, acc_clr);
        end
        capture(60);
        n_vec++;
        if ({sched_errs(1), rv_cyc} !== {32'd0, 32'd23}) begin n_bad++; $display("FAIL b2b_second_run got bad=%0d cyc=%0d want 0/23", sched_errs(1), rv_cyc); end
    endtask

    initial begin
        test_reset();
        test_ab1();
        test_compare();
        test_trunc();
        test_other();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hdc_classify_ctrl.md
# hdc_classify_ctrl

Sequencer for the hyperdimensional spam/ham classifier datapath. It accepts a message as a byte stream and tokenizes each character into an item-memory index. It then steps the external encoder/similarity datapath through its passes (clear, accumulate, threshold, score), one vector word per cycle. It finishes by comparing the ham and spam dot-product scores and issuing the classification result.

## Interface
- DIM, 10000: hypervector dimension.
- LANES, 16: dimensions per datapath word. DIM % LANES must be 0. WORDS = DIM/LANES.
- NUM_CHAR, 37: item-memory entries (token range 0..36).
- MAX_LENGTH, 200: token buffer depth.
- PIPE_LAT, 3: datapath pipeline latency in cycles. Must satisfy 1 ≤ PIPE_LAT < WORDS.
- SCORE_W, 32: signed score width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  character byte valid.
- char_data  in  8  ASCII byte.
- char_last  in  1  final byte of message, qualified by char_valid.
- char_ready  out  1  controller can accept a byte.
- word_addr  out  clog2(WORDS)  datapath word index for the current strobe.
- im_token  out  clog2(NUM_CHAR)  item-memory row; meaningful while acc_en is high.
- acc_clr  out  1  zero the accumulator word.
- acc_en  out  1  add item-memory word im_token into the accumulator word.
- thr_en  out  1  binarize the accumulator word against the average.
- dot_en  out  1  accumulate dot products for ham and spam.
- msg_len  out  8  number of tokens in the buffered message. Stable from CLEAR until the next message.
- ham_score, spam_score  in  SCORE_W  signed dot products. Valid once the SCORE drain completes.
- result  out  2  classification: 2'b00 ham, 2'b01 spam, 2'b11 tie.
- result_valid  out  1  one-cycle pulse.
- busy  out  1  high in every state except IDLE and LOAD.
- trunc  out  1  message exceeded MAX_LENGTH. Cleared at the start of the next message.

## Operation
- States: IDLE → LOAD → CLEAR → ACCUM → DRAIN_A → THRESH → DRAIN_T → SCORE → DRAIN_S → DONE → IDLE.
- char_ready = 1 in IDLE and LOAD only. A byte is accepted on char_valid & char_ready. The first accepted byte moves IDLE to LOAD.
- Tokenize each byte:
  - Uppercase 'A'..'Z' is lowercased first.
  - 'a'..'z' → 11..36.
  - '0'..'9' → 1..10.
  - Anything else → 0.
- Accepted tokens are written to the buffer in order.
  - Tokens beyond MAX_LENGTH are discarded and set trunc.
  - msg_len saturates at MAX_LENGTH.
- Accepting a byte with char_last moves to CLEAR. If the message holds zero tokens (possible only with the macro), go straight to DONE with result = 2'b11.
- CLEAR: acc_clr high for WORDS cycles, with word_addr counting 0..WORDS-1.
- ACCUM: for each token t = 0..msg_len-1, acc_en is high for WORDS cycles with im_token = buf[t] and word_addr 0..WORDS-1.
  - The sweeps are back to back, with no gap between tokens.
- DRAIN_x: all strobes low for PIPE_LAT cycles.
- THRESH: thr_en high while word_addr sweeps 0..WORDS-1.
- SCORE: dot_en high while word_addr sweeps 0..WORDS-1.
- DONE: compare ham_score and spam_score as signed values:
  - ham_score > spam_score → 2'b00.
  - ham_score < spam_score → 2'b01.
  - equal → 2'b11.
  - result is registered, result_valid pulses, and the state returns to IDLE.
- At most one of acc_clr, acc_en, thr_en, dot_en is high in any cycle.
- word_addr wraps WORDS-1 → 0 at the end of each sweep and holds 0 when no strobe is active.

## Timing
- Reset values:
  - state IDLE, char_ready 1, busy 0.
  - All strobes 0, word_addr 0, im_token 0.
  - msg_len 0, result 2'b00, result_valid 0, trunc 0.
- Reset asserted mid-operation aborts immediately. The buffer contents become don't-care.
- Cycle 1 = first cycle after the char_last acceptance. Then:
  - CLEAR occupies cycles 1..WORDS.
  - ACCUM occupies WORDS+1 .. (N+1)·WORDS, where N = msg_len.
  - THRESH, SCORE and the three drains follow in order.
- result_valid is high in cycle (N+3)·WORDS + 3·PIPE_LAT + 1. result holds until the next DONE.
- The first new byte is accepted in the cycle after result_valid (state IDLE).
- char_valid while busy is ignored; no byte is lost because char_ready = 0.

## Configuration
- HDC_SKIP_OTHER_EN defined: bytes that map to token 0 are accepted but not buffered or counted. char_last on such a byte still ends the message.
- HDC_SKIP_OTHER_EN undefined: token-0 bytes are buffered and encoded like any other token.

## Test plan
Test parameters: DIM=64, LANES=16 (WORDS=4), PIPE_LAT=2, MAX_LENGTH=4, unless noted.

- "Ab1" with ham_score=100, spam_score=-5:
  - im_token sequence is 11,12,2, each held for 4 acc_en cycles.
  - result=2'b00; result_valid lands in cycle 31.
- Same message with ham_score=spam_score=7: result=2'b11. With ham=-3, spam=4: result=2'b01.
- "abcdef": msg_len=4, trunc=1, ACCUM lasts 16 cycles; tokens 11..14 only.
- "a-b", macro undefined: tokens 11,0,12, msg_len=3. Macro defined: tokens 11,12, msg_len=2.
- Assert reset in the 3rd ACCUM cycle: all outputs return to reset values asynchronously; char_ready=1 after release.
- char_valid held high through busy: no byte accepted until IDLE; strobes never overlap; word_addr wraps 3→0 at each token boundary.
